// File: rtl/mig_phrase_pkg.sv
// Shared definitions for the MIG phrase controller: command encodings, widths, and FSM states.
package mig_phrase_pkg;
  localparam int PHRASE_W   = 128;
  localparam int APP_ADDR_W = 27;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [0:0] {
    ST_CALIB = 1'b0,
    ST_RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/phrase_fifo.sv
// Synchronous FIFO with occupancy count, used as the read-return buffer.
// DEPTH must be a power of two; the head is visible the cycle after a push into an empty FIFO.
module phrase_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_idx_r;
  logic [AW-1:0]    rd_idx_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign pop_s  = pop && (count_r != {(AW+1){1'b0}});
  assign push_s = push && ((count_r != (AW+1)'(DEPTH)) || pop_s);

  // Storage array; left unreset because the head output is gated by empty
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_idx_r] <= push_data;
    end
  end

  // Index and occupancy tracking
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_idx_r <= {AW{1'b0}};
      rd_idx_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_idx_r <= wr_idx_r + AW'(1);
      if (pop_s)  rd_idx_r <= rd_idx_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign empty     = (count_r == {(AW+1){1'b0}});
  assign head_data = empty ? {WIDTH{1'b0}} : mem_r[rd_idx_r];
  assign count     = count_r;
endmodule

// File: rtl/mig_phrase_ctrl.sv
// Phrase-stream <-> MIG app_* endpoint with wrapping frame pointers and credit-limited reads.
// Optional macro MIG_PHRASE_WR_PRIORITY_EN: writes win every tie instead of round-robin.
module mig_phrase_ctrl
  import mig_phrase_pkg::*;
#(
  parameter int FRAME_PHRASES = 9600,
  parameter int ADDR_STEP     = 8,
  parameter int RD_DEPTH      = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  init_calib_complete,
  input  logic                  wr_phrase_valid,
  output logic                  wr_phrase_ready,
  input  logic [PHRASE_W-1:0]   wr_phrase_data,
  output logic                  rd_phrase_valid,
  input  logic                  rd_phrase_ready,
  output logic [PHRASE_W-1:0]   rd_phrase_data,
  output logic [APP_ADDR_W-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [PHRASE_W-1:0]   app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [PHRASE_W-1:0]   app_rd_data,
  input  logic                  app_rd_data_valid
);
  localparam int PTR_W = $clog2(FRAME_PHRASES);
  localparam int CNT_W = $clog2(RD_DEPTH) + 1;

  state_e                state_r;
  state_e                state_nxt_s;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      outstanding_r;
  logic [CNT_W-1:0]      buf_count_s;
  logic [CNT_W:0]        credit_used_s;
  logic                  wr_elig_s;
  logic                  rd_elig_s;
  logic                  grant_wr_s;
  logic                  grant_rd_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  ret_push_s;
  logic                  pop_s;
  logic                  buf_empty_s;
  logic [APP_ADDR_W-1:0] wr_addr_s;
  logic [APP_ADDR_W-1:0] rd_addr_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FRAME_PHRASES - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Buffered plus in-flight reads may never exceed the buffer depth
  assign credit_used_s = {1'b0, buf_count_s} + {1'b0, outstanding_r};
  assign wr_addr_s     = APP_ADDR_W'(wr_ptr_r) * APP_ADDR_W'(ADDR_STEP);
  assign rd_addr_s     = APP_ADDR_W'(rd_ptr_r) * APP_ADDR_W'(ADDR_STEP);

`ifndef MIG_PHRASE_WR_PRIORITY_EN
  logic last_wr_r;

  // Remember which side was last accepted so ties alternate
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_wr_r <= 1'b0;
    end else if (wr_acc_s) begin
      last_wr_r <= 1'b1;
    end else if (rd_acc_s) begin
      last_wr_r <= 1'b0;
    end else begin
      last_wr_r <= last_wr_r;
    end
  end
`endif

  // Calibration state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_CALIB;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, arbitration and command outputs
  always_comb begin
    state_nxt_s = state_r;
    grant_wr_s  = 1'b0;
    grant_rd_s  = 1'b0;
    app_en      = 1'b0;
    app_cmd     = CMD_READ;
    app_addr    = {APP_ADDR_W{1'b0}};
    case (state_r)
      ST_CALIB: state_nxt_s = init_calib_complete ? ST_RUN : ST_CALIB;
      ST_RUN:   state_nxt_s = init_calib_complete ? ST_RUN : ST_CALIB;
      default:  state_nxt_s = ST_CALIB;
    endcase
    wr_elig_s = (state_r == ST_RUN) && wr_phrase_valid && app_wdf_rdy;
    rd_elig_s = (state_r == ST_RUN) && (credit_used_s < (CNT_W+1)'(RD_DEPTH));
    if (wr_elig_s && rd_elig_s) begin
`ifdef MIG_PHRASE_WR_PRIORITY_EN
      grant_wr_s = 1'b1;
      grant_rd_s = 1'b0;
`else
      grant_wr_s = !last_wr_r;
      grant_rd_s = last_wr_r;
`endif
    end else begin
      grant_wr_s = wr_elig_s;
      grant_rd_s = rd_elig_s;
    end
    app_en = grant_wr_s || grant_rd_s;
    if (grant_wr_s) begin
      app_cmd  = CMD_WRITE;
      app_addr = wr_addr_s;
    end else if (grant_rd_s) begin
      app_cmd  = CMD_READ;
      app_addr = rd_addr_s;
    end else begin
      app_cmd  = CMD_READ;
      app_addr = {APP_ADDR_W{1'b0}};
    end
  end

  assign wr_acc_s        = grant_wr_s && app_rdy;
  assign rd_acc_s        = grant_rd_s && app_rdy;
  assign wr_phrase_ready = wr_acc_s;
  assign app_wdf_wren    = wr_acc_s;
  assign app_wdf_end     = wr_acc_s;
  assign app_wdf_data    = wr_phrase_data;
  // Returns with nothing outstanding are stale beats from before a reset
  assign ret_push_s      = app_rd_data_valid && (outstanding_r != {CNT_W{1'b0}});
  assign rd_phrase_valid = !buf_empty_s;
  assign pop_s           = !buf_empty_s && rd_phrase_ready;

  // Frame pointers and in-flight read count
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      outstanding_r <= {CNT_W{1'b0}};
    end else begin
      if (wr_acc_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (rd_acc_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({rd_acc_s, ret_push_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  phrase_fifo #(
    .DEPTH (RD_DEPTH),
    .WIDTH (PHRASE_W)
  ) u_rd_buf (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (ret_push_s),
    .push_data (app_rd_data),
    .pop       (pop_s),
    .head_data (rd_phrase_data),
    .empty     (buf_empty_s),
    .count     (buf_count_s)
  );
endmodule

// File: tb/tb_mig_phrase_ctrl.sv
// Self-checking bench for mig_phrase_ctrl: directed scenarios plus randomized traffic vs a queue-based model.
module tb_mig_phrase_ctrl;
  localparam int FRAME = 9600;
  localparam int STEP  = 8;
  localparam int DEPTH = 16;

  logic         clk_in = 1'b0;
  logic         rst_in, init_calib_complete, wr_phrase_valid, rd_phrase_ready;
  logic         app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [127:0] wr_phrase_data, app_rd_data;
  logic         wr_phrase_ready, rd_phrase_valid, app_en, app_wdf_wren, app_wdf_end;
  logic [127:0] rd_phrase_data, app_wdf_data;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic [34:0]  obs_ctrl;

  always #5 clk_in = ~clk_in;

  mig_phrase_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .init_calib_complete(init_calib_complete),
    .wr_phrase_valid(wr_phrase_valid), .wr_phrase_ready(wr_phrase_ready),
    .wr_phrase_data(wr_phrase_data), .rd_phrase_valid(rd_phrase_valid),
    .rd_phrase_ready(rd_phrase_ready), .rd_phrase_data(rd_phrase_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  assign obs_ctrl = {app_en, app_cmd, app_addr, wr_phrase_ready, app_wdf_wren, app_wdf_end, rd_phrase_valid};

  // Reference model state: frame indices, in-flight reads, and the buffered return data
  bit           m_run, m_last_wr, g_wr, g_rd;
  int           m_wr_ptr, m_rd_ptr, m_out;
  logic [127:0] m_buf[$];
  logic [34:0]  exp_ctrl;
  logic [127:0] exp_rdata;
  int           n_checks = 0;
  int           n_fail = 0;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_last_wr = 1'b0; m_wr_ptr = 0; m_rd_ptr = 0; m_out = 0;
    m_buf.delete();
  endtask

  task automatic eval_model();
    bit wr_el, rd_el, ewr, een, erv;
    logic [2:0]  ecmd;
    logic [26:0] eaddr;
    wr_el = m_run && wr_phrase_valid && app_wdf_rdy;
    rd_el = m_run && ((m_buf.size() + m_out) < DEPTH);
    g_wr = 1'b0; g_rd = 1'b0;
    if (wr_el && rd_el) begin
`ifdef MIG_PHRASE_WR_PRIORITY_EN
      g_wr = 1'b1;
`else
      if (m_last_wr) g_rd = 1'b1; else g_wr = 1'b1;
`endif
    end else begin
      g_wr = wr_el; g_rd = rd_el;
    end
    een   = g_wr || g_rd;
    ecmd  = g_wr ? 3'b000 : 3'b001;
    eaddr = g_wr ? 27'(m_wr_ptr * STEP) : (g_rd ? 27'(m_rd_ptr * STEP) : 27'd0);
    ewr   = g_wr && app_rdy;
    erv   = (m_buf.size() != 0);
    exp_ctrl  = {een, ecmd, eaddr, ewr, ewr, ewr, erv};
    exp_rdata = erv ? m_buf[0] : 128'd0;
  endtask

  // Commit the model with the inputs the DUT samples at the coming edge, then advance to the next negedge
  task automatic tick();
    bit wacc, racc, ret;
    eval_model();
    wacc = g_wr && app_rdy;
    racc = g_rd && app_rdy;
    if (wacc) m_wr_ptr = (m_wr_ptr + 1) % FRAME;
    if (racc) m_rd_ptr = (m_rd_ptr + 1) % FRAME;
    if (m_buf.size() != 0 && rd_phrase_ready) void'(m_buf.pop_front());
    ret = app_rd_data_valid && (m_out > 0);
    if (ret) m_buf.push_back(app_rd_data);
    m_out = m_out + (racc ? 1 : 0) - (ret ? 1 : 0);
    if (wacc) m_last_wr = 1'b1;
    else if (racc) m_last_wr = 1'b0;
    m_run = init_calib_complete;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic set_idle();
    init_calib_complete = 1'b0; wr_phrase_valid = 1'b0; rd_phrase_ready = 1'b0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
    wr_phrase_data = 128'd0; app_rd_data = 128'd0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (obs_ctrl !== {1'b0, 3'b001, 27'd0, 4'b0000}) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected %h", obs_ctrl, {1'b0, 3'b001, 27'd0, 4'b0000});
    end
    n_checks++;
    if (rd_phrase_data !== 128'd0 || app_wdf_data !== 128'd0) begin
      n_fail++; $display("FAIL reset_data: got rd %h wdf %h expected 0", rd_phrase_data, app_wdf_data);
    end
    tick();
  endtask

  task automatic test_calib_gate();
    do_reset();
    wr_phrase_valid = 1'b1; wr_phrase_data = rand128(); app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++;
      if ({app_en, wr_phrase_ready} !== 2'b00) begin
        n_fail++; $display("FAIL calib_gate cyc %0d: got en/ready %b expected 00", i, {app_en, wr_phrase_ready});
      end
      tick();
    end
    init_calib_complete = 1'b1;
    #1;
    n_checks++;
    if (app_en !== 1'b0) begin
      n_fail++; $display("FAIL calib_raise_same_cycle: got app_en %b expected 0", app_en);
    end
    tick();
    #1;
    n_checks++;
    if ({app_en, app_cmd, app_addr, wr_phrase_ready} !== {1'b1, 3'b000, 27'd0, 1'b1}) begin
      n_fail++; $display("FAIL calib_first_write: got en %b cmd %b addr %0d rdy %b expected 1 000 0 1",
                         app_en, app_cmd, app_addr, wr_phrase_ready);
    end
    tick();
  endtask

  task automatic test_write_wrap();
    int writes, cyc;
    do_reset();
    init_calib_complete = 1'b1; wr_phrase_valid = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    tick();
    writes = 0; cyc = 0;
    while (writes < FRAME + 1 && cyc < 12000) begin
      wr_phrase_data = rand128();
      #1;
      eval_model();
      n_checks++;
      if (obs_ctrl !== exp_ctrl) begin
        n_fail++; $display("FAIL wrap_ctrl cyc %0d: got %h expected %h", cyc, obs_ctrl, exp_ctrl);
      end
      if (g_wr) begin
        if (writes == FRAME - 1) begin
          n_checks++;
          if (app_addr !== 27'd76792) begin
            n_fail++; $display("FAIL wrap_last_addr: got %0d expected 76792", app_addr);
          end
        end
        if (writes == FRAME) begin
          n_checks++;
          if (app_addr !== 27'd0) begin
            n_fail++; $display("FAIL wrap_to_zero: got %0d expected 0", app_addr);
          end
        end
        writes++;
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (writes < FRAME + 1) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d writes expected %0d", writes, FRAME + 1);
    end
    wr_phrase_valid = 1'b0;
    #1;
    n_checks++;
    if (app_en !== 1'b0) begin
      n_fail++; $display("FAIL wrap_reads_capped: got app_en %b expected 0", app_en);
    end
    tick();
  endtask

  task automatic test_credit_limit();
    int cnt;
    logic [127:0] ret;
    do_reset();
    init_calib_complete = 1'b1; app_rdy = 1'b1;
    tick();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (app_en && app_cmd == 3'b001) cnt++;
      tick();
    end
    n_checks++;
    if (cnt !== 16) begin
      n_fail++; $display("FAIL credit_first: got %0d reads expected 16", cnt);
    end
    rd_phrase_ready = 1'b1;
    ret = rand128();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      app_rd_data_valid = (i == 0); app_rd_data = (i == 0) ? ret : 128'd0;
      #1;
      if (app_en && app_cmd == 3'b001) cnt++;
      if (i == 1) begin
        n_checks++;
        if (rd_phrase_valid !== 1'b1 || rd_phrase_data !== ret) begin
          n_fail++; $display("FAIL credit_return_data: got v %b %h expected 1 %h", rd_phrase_valid, rd_phrase_data, ret);
        end
      end
      tick();
    end
    n_checks++;
    if (cnt !== 1) begin
      n_fail++; $display("FAIL credit_one_more: got %0d reads expected 1", cnt);
    end
  endtask

  task automatic test_tie_arb();
    logic [2:0] want;
    do_reset();
    init_calib_complete = 1'b1; wr_phrase_valid = 1'b1; app_wdf_rdy = 1'b1; app_rdy = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
`ifdef MIG_PHRASE_WR_PRIORITY_EN
      want = 3'b000;
`else
      want = (i % 2 == 0) ? 3'b000 : 3'b001;
`endif
      #1;
      n_checks++;
      if ({app_en, app_cmd} !== {1'b1, want}) begin
        n_fail++; $display("FAIL tie_arb cyc %0d: got en %b cmd %b expected 1 %b", i, app_en, app_cmd, want);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    init_calib_complete = 1'b1; wr_phrase_valid = 1'b1; app_wdf_rdy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({app_en, wr_phrase_ready, app_addr} !== {1'b1, 1'b0, 27'd0}) begin
        n_fail++; $display("FAIL bp_app_rdy_low cyc %0d: got en %b rdy %b addr %0d expected 1 0 0",
                           i, app_en, wr_phrase_ready, app_addr);
      end
      tick();
    end
    app_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      eval_model();
      n_checks++;
      if (obs_ctrl !== exp_ctrl) begin
        n_fail++; $display("FAIL bp_release cyc %0d: got %h expected %h", i, obs_ctrl, exp_ctrl);
      end
      tick();
    end
    app_wdf_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (wr_phrase_ready !== 1'b0 || (app_en === 1'b1 && app_cmd !== 3'b001)) begin
        n_fail++; $display("FAIL bp_wdf_low cyc %0d: got rdy %b en %b cmd %b expected only reads",
                           i, wr_phrase_ready, app_en, app_cmd);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset();
    init_calib_complete = 1'b1; app_rdy = 1'b1;
    tick();
    guard = 0;
    while (m_out < 7 && guard < 20) begin
      tick();
      guard++;
    end
    app_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      app_rd_data_valid = 1'b1; app_rd_data = rand128();
      tick();
    end
    app_rd_data_valid = 1'b0;
    #1;
    n_checks++;
    if (rd_phrase_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got rd_valid %b expected 1", rd_phrase_valid);
    end
    #1;
    rst_in = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({rd_phrase_valid, app_en, app_cmd} !== {1'b0, 1'b0, 3'b001}) begin
      n_fail++; $display("FAIL areset_immediate: got v %b en %b cmd %b expected 0 0 001", rd_phrase_valid, app_en, app_cmd);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      app_rd_data_valid = 1'b1; app_rd_data = rand128();
      #1;
      eval_model();
      n_checks++;
      if (rd_phrase_valid !== 1'b0 || obs_ctrl !== exp_ctrl) begin
        n_fail++; $display("FAIL areset_stale cyc %0d: got %h expected %h", i, obs_ctrl, exp_ctrl);
      end
      tick();
    end
    app_rd_data_valid = 1'b0;
    #1;
    n_checks++;
    if (rd_phrase_valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_after_stale: got rd_valid %b expected 0", rd_phrase_valid);
    end
    wr_phrase_valid = 1'b1; app_wdf_rdy = 1'b1;
    #1;
    n_checks++;
    if ({app_en, app_cmd, app_addr} !== {1'b1, 3'b000, 27'd0}) begin
      n_fail++; $display("FAIL areset_wr_ptr: got en %b cmd %b addr %0d expected 1 000 0", app_en, app_cmd, app_addr);
    end
    tick();
    wr_phrase_valid = 1'b0;
    #1;
    n_checks++;
    if ({app_en, app_cmd, app_addr} !== {1'b1, 3'b001, 27'd0}) begin
      n_fail++; $display("FAIL areset_rd_ptr: got en %b cmd %b addr %0d expected 1 001 0", app_en, app_cmd, app_addr);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      init_calib_complete = ($urandom_range(0, 99) > 2);
      wr_phrase_valid     = ($urandom_range(0, 9) < 7);
      wr_phrase_data      = rand128();
      rd_phrase_ready     = $urandom_range(0, 1);
      app_rdy             = ($urandom_range(0, 3) != 0);
      app_wdf_rdy         = ($urandom_range(0, 4) != 0);
      app_rd_data_valid   = (m_out > 0) && ($urandom_range(0, 1) == 1);
      app_rd_data         = rand128();
      #1;
      eval_model();
      n_checks++;
      if (obs_ctrl !== exp_ctrl) begin
        n_fail++; $display("FAIL random_ctrl cyc %0d: got %h expected %h", i, obs_ctrl, exp_ctrl);
      end
      n_checks++;
      if ((exp_ctrl[0] && rd_phrase_data !== exp_rdata) || app_wdf_data !== wr_phrase_data) begin
        n_fail++; $display("FAIL random_data cyc %0d: got %h expected %h", i, rd_phrase_data, exp_rdata);
      end
      tick();
    end
  endtask

  initial begin
    rst_in = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_calib_gate();
    test_tie_arb();
    test_backpressure();
    test_credit_limit();
    test_async_reset();
    test_write_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
